// File: rtl/uart_bitvec_pkg.sv
// Shared opcodes, field masks and TX state encoding for the UART bit-vector bridge.
package uart_bitvec_pkg;

  localparam logic [7:0] OP_CLEAR   = 8'hC0;
  localparam logic [7:0] OP_DUMP    = 8'hC1;
  localparam logic [7:0] OP_AUTO    = 8'hC2;

  localparam logic [7:0] OP_WR_MASK = 8'h80;
  localparam logic [7:0] OP_WR_VAL  = 8'h00;
  localparam logic [7:0] OP_PG_MASK = 8'hC0;
  localparam logic [7:0] OP_PG_VAL  = 8'h80;

  localparam int unsigned PAGE_BITS = 6;
  localparam int unsigned ADDR_BITS = 6;
  localparam int unsigned BIT_IDX_W = PAGE_BITS + ADDR_BITS;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2,
    TERM   = 2'd3
  } tx_state_t;

  function automatic logic [7:0] ascii_bit(input logic b);
    return ASCII_ZERO | {7'd0, b};
  endfunction

endpackage

// File: rtl/uart_bitvec_tx.sv
// Settle timer, vec_in snapshot and frame serialiser ('0'/'1' bytes LSB first, then terminator).
module uart_bitvec_tx
  import uart_bitvec_pkg::*;
#(
  parameter int unsigned OUT_W      = 64,
  parameter int unsigned SETTLE_CYC = 16,
  parameter logic [7:0]  TERM_CHAR  = 8'h2A
) (
  input  logic             clk_48mhz,
  input  logic             reset,
  input  logic             req_i,
  input  logic             vec_chg_i,
  input  logic [OUT_W-1:0] vec_in_i,
  input  logic             tx_ready_i,
  output logic             take_c,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned IDX_W = $clog2(OUT_W + 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nx;
  logic [OUT_W-1:0] snap_q, snap_d, snap_shift;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;

  // Settle timer: any vec_out change restarts the wait, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (vec_chg_i) begin
      cnt_d = CNT_W'(SETTLE_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign idx_nx     = idx_q + IDX_W'(1);
  assign snap_shift = snap_q >> idx_nx;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    take_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = SETTLE;
          take_c  = 1'b1;
        end
      end
      SETTLE: begin
        // A change landing on the zero cycle would make the snapshot stale, so wait again.
        if (cnt_q == '0 && !vec_chg_i) begin
          snap_d     = vec_in_i;
          idx_d      = '0;
          state_d    = SEND;
          tx_valid_d = 1'b1;
          tx_data_d  = ascii_bit(vec_in_i[0]);
        end
      end
      SEND: begin
        if (tx_valid_q && tx_ready_i) begin
          if (idx_q == IDX_W'(OUT_W - 1)) begin
            state_d   = TERM;
            tx_data_d = TERM_CHAR;
          end else begin
            idx_d     = idx_nx;
            tx_data_d = ascii_bit(snap_shift[0]);
          end
        end
      end
      TERM: begin
        if (tx_valid_q && tx_ready_i) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_W'(SETTLE_CYC);
      idx_q      <= '0;
      snap_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;

endmodule

// File: rtl/uart_bitvec_bridge.sv
// Host byte decoder driving a paged bit-vector into the logic under test and returning
// vec_in snapshots as ASCII frames through uart_bitvec_tx.
module uart_bitvec_bridge
  import uart_bitvec_pkg::*;
#(
  parameter int unsigned IN_W       = 64,
  parameter int unsigned OUT_W      = 64,
  parameter int unsigned SETTLE_CYC = 16,
  parameter logic [7:0]  TERM_CHAR  = 8'h2A,
  parameter logic        AUTO_RST   = 1'b1
) (
  input  logic             clk_48mhz,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [IN_W-1:0]  vec_out,
  input  logic [OUT_W-1:0] vec_in,
  output logic             auto_mode,
  output logic             addr_err
);

  logic [IN_W-1:0]      vec_out_q, vec_out_d, bit_mask;
  logic [PAGE_BITS-1:0] page_q, page_d;
  logic                 auto_q, auto_d;
  logic                 err_q, err_d;
  logic                 pend_q, pend_d;
  logic                 rx_ready_q;
  logic                 accept, dump_req, in_range, vec_chg, take_c;
  logic [BIT_IDX_W-1:0] bit_idx;

  assign accept   = rx_valid && rx_ready_q;
  assign bit_idx  = {page_q, rx_data[ADDR_BITS:1]};
  assign in_range = 32'(bit_idx) < IN_W;
  assign bit_mask = IN_W'(1) << bit_idx;

  // Command decode: write-bit, set-page, and the 11xxxxxx control opcodes.
  always_comb begin
    vec_out_d = vec_out_q;
    page_d    = page_q;
    auto_d    = auto_q;
    err_d     = err_q;
    dump_req  = 1'b0;
    if (accept) begin
      if ((rx_data & OP_WR_MASK) == OP_WR_VAL) begin
        if (in_range) begin
          vec_out_d = rx_data[0] ? (vec_out_q | bit_mask) : (vec_out_q & ~bit_mask);
        end else begin
          err_d = 1'b1;
        end
      end else if ((rx_data & OP_PG_MASK) == OP_PG_VAL) begin
        page_d = rx_data[PAGE_BITS-1:0];
      end else begin
        case (rx_data)
          OP_CLEAR: vec_out_d = '0;
          OP_DUMP:  dump_req  = 1'b1;
          OP_AUTO:  auto_d    = ~auto_q;
          default:  ;
        endcase
      end
    end
  end

  // A request arriving in the same cycle the TX side starts a frame merges into that frame.
  always_comb begin
    pend_d = pend_q;
    if (take_c) begin
      pend_d = 1'b0;
    end else if (dump_req) begin
      pend_d = 1'b1;
    end
  end

  assign vec_chg = (vec_out_d != vec_out_q);

  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      vec_out_q  <= '0;
      page_q     <= '0;
      auto_q     <= AUTO_RST;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      vec_out_q  <= vec_out_d;
      page_q     <= page_d;
      auto_q     <= auto_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
      rx_ready_q <= 1'b1;
    end
  end

  uart_bitvec_tx #(
    .OUT_W      (OUT_W),
    .SETTLE_CYC (SETTLE_CYC),
    .TERM_CHAR  (TERM_CHAR)
  ) u_tx (
    .clk_48mhz  (clk_48mhz),
    .reset      (reset),
    .req_i      (pend_q || auto_q),
    .vec_chg_i  (vec_chg),
    .vec_in_i   (vec_in),
    .tx_ready_i (tx_ready),
    .take_c     (take_c),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid)
  );

  assign rx_ready  = rx_ready_q;
  assign vec_out   = vec_out_q;
  assign auto_mode = auto_q;
  assign addr_err  = err_q;

endmodule
